mul_hazard_unit: RTL

- Issue-side scoreboard for the 4-stage pipelined multiplier.
- Tracks the destination register of every in-flight multiply until it writes back.
- Stalls decode on RAW hazards, WAW hazards and writeback-port collisions with single-cycle ALU results.
- Checks each multiplier retirement (regmul/Rd at the pipeline output) against the expected schedule and flags mismatches.

---
 rtl/mul_hazard_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/mul_hazard_unit.sv
// Issue-side scoreboard for the pipelined multiplier: tracks in-flight mul destinations,
// stalls decode on RAW/WAW/writeback-port hazards and audits every multiplier retirement.
module mul_hazard_unit #(
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned ALU_WB_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_is_mul,
    input  logic        dec_writes_rd,
    input  logic [4:0]  dec_rd,
    input  logic        dec_uses_rs1,
    input  logic [4:0]  dec_rs1,
    input  logic        dec_uses_rs2,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_valid,
    input  logic        wb_regmul,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic        raw_hazard,
    output logic        waw_hazard,
    output logic        wb_conflict,
    output logic [31:0] pending_mask,
    output logic        wb_err
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [MUL_LAT:1] wb_slot_q;
    logic [MUL_LAT:1] wb_slot_d;
    logic             wb_err_q;
    logic             wb_err_d;

    logic [31:0]      cnt_one;
    logic             issue;
    logic             mul_issue;

    // Flattened per-register views so lookups can be indexed by any 5-bit id, x0 included.
    always_comb begin
        pending_mask = '0;
        cnt_one      = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
            cnt_one[r]      = (cnt_q[r] == CNT_W'(1));
        end
    end

    always_comb begin
        raw_hazard  = dec_valid &
                      ((dec_uses_rs1 & (dec_rs1 != 5'd0) & pending_mask[dec_rs1]) |
                       (dec_uses_rs2 & (dec_rs2 != 5'd0) & pending_mask[dec_rs2]));
        waw_hazard  = dec_valid & dec_writes_rd & (dec_rd != 5'd0) & pending_mask[dec_rd];
        wb_conflict = dec_valid & dec_writes_rd & ~dec_is_mul & wb_slot_q[ALU_WB_LAT];
        stall       = raw_hazard | waw_hazard | wb_conflict;
        issue       = dec_valid & ~stall;
        mul_issue   = issue & dec_is_mul;
    end

    always_comb begin
        for (int unsigned r = 1; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
            if (mul_issue && (dec_rd == r[4:0])) begin
                cnt_d[r] = CNT_W'(MUL_LAT);
            end
        end
    end

    always_comb begin
        wb_slot_d = '0;
        for (int unsigned k = 1; k < MUL_LAT; k++) begin
            wb_slot_d[k] = wb_slot_q[k+1];
        end
        wb_slot_d[MUL_LAT] = mul_issue;
    end

    // A retirement is legal only in the last cycle of its counter; a scheduled slot with no retirement is an error.
    always_comb begin
        wb_err_d = wb_err_q;
        if (wb_regmul && (wb_rd != 5'd0) && !cnt_one[wb_rd]) begin
            wb_err_d = 1'b1;
        end
        if (!wb_regmul && wb_slot_q[1]) begin
            wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            wb_slot_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wb_slot_q <= wb_slot_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

endmodule
